// File: rtl/zz_pkg.sv
// rtl/zz_pkg.sv - zigzag scan table, read FSM encoding and width default for dct_zigzag_reader
package zz_pkg;

  localparam int ZZ_DATA_WIDTH = 14;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  // JPEG zigzag scan: entry i is the raster address v*8+u of the i-th coefficient
  localparam logic [5:0] ZZ_ORDER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_order_rom.sv
// rtl/zz_order_rom.sv - combinational zigzag position to raster address lookup
module zz_order_rom
  import zz_pkg::*;
(
  input  logic [5:0] idx,
  output logic [5:0] addr
);

  assign addr = ZZ_ORDER[idx];

endmodule

// File: rtl/dct_zigzag_reader.sv
// rtl/dct_zigzag_reader.sv - ping-pong 8x8 coefficient buffer streamed out in zigzag order
// Optional ZZ_RASTER_EN adds I_raster to stream selected blocks in raster order.
module dct_zigzag_reader
  import zz_pkg::*;
#(
  parameter int DATA_WIDTH = ZZ_DATA_WIDTH
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_en,
  input  logic                         I_vec_valid,
  input  logic signed [DATA_WIDTH-1:0] I_dct_0,
  input  logic signed [DATA_WIDTH-1:0] I_dct_1,
  input  logic signed [DATA_WIDTH-1:0] I_dct_2,
  input  logic signed [DATA_WIDTH-1:0] I_dct_3,
  input  logic signed [DATA_WIDTH-1:0] I_dct_4,
  input  logic signed [DATA_WIDTH-1:0] I_dct_5,
  input  logic signed [DATA_WIDTH-1:0] I_dct_6,
  input  logic signed [DATA_WIDTH-1:0] I_dct_7,
  output logic                         O_stall,
  output logic                         O_overflow,
  output logic                         O_valid,
  input  logic                         I_ready,
  output logic signed [DATA_WIDTH-1:0] O_data,
  output logic [5:0]                   O_index,
  output logic                         O_last
`ifdef ZZ_RASTER_EN
  ,
  input  logic                         I_raster
`endif
);

  // Bank select is the MSB of the address: {bank, v[2:0], u[2:0]}
  logic signed [DATA_WIDTH-1:0] mem [0:127];
  logic signed [DATA_WIDTH-1:0] vec [0:7];

  logic [2:0] wr_col;
  logic       wr_bank;
  logic [1:0] bank_full, bank_full_nxt;
  logic       wr_fire, wr_drop;

  rd_state_e  state, state_nxt;
  logic       rd_bank, rd_bank_nxt;
  logic [5:0] idx, idx_nxt;
  logic       beat, blk_done;
  logic [5:0] zz_addr, rd_addr;
  logic       raster_mode;

  assign vec[0] = I_dct_0;
  assign vec[1] = I_dct_1;
  assign vec[2] = I_dct_2;
  assign vec[3] = I_dct_3;
  assign vec[4] = I_dct_4;
  assign vec[5] = I_dct_5;
  assign vec[6] = I_dct_6;
  assign vec[7] = I_dct_7;

  assign wr_fire = I_en & I_vec_valid & ~bank_full[wr_bank];
  assign wr_drop = I_en & I_vec_valid & bank_full[wr_bank];
  assign O_stall = bank_full[wr_bank];

  always_ff @(posedge I_clk) begin
    if (wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        mem[{wr_bank, 3'(k), wr_col}] <= vec[k];
      end
    end
  end

  // Fill and free always hit different banks: a bank is written only while not full
  always_comb begin
    bank_full_nxt = bank_full;
    if (blk_done) bank_full_nxt[rd_bank] = 1'b0;
    if (wr_fire && wr_col == 3'd7) bank_full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_col     <= 3'd0;
      wr_bank    <= 1'b0;
      bank_full  <= 2'b00;
      O_overflow <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_col <= wr_col + 3'd1;
        if (wr_col == 3'd7) wr_bank <= ~wr_bank;
      end
      if (wr_drop) O_overflow <= 1'b1;
      bank_full <= bank_full_nxt;
    end
  end

  assign beat     = (state == STREAM) & I_ready & I_en;
  assign blk_done = beat & (idx == 6'd63);

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    rd_bank_nxt = rd_bank;
    case (state)
      IDLE: begin
        if (I_en && bank_full[rd_bank]) begin
          state_nxt = STREAM;
          idx_nxt   = 6'd0;
        end
      end
      STREAM: begin
        if (beat) begin
          idx_nxt = idx + 6'd1;
          if (idx == 6'd63) begin
            rd_bank_nxt = ~rd_bank;
            if (!bank_full[~rd_bank]) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= IDLE;
      idx     <= 6'd0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

`ifdef ZZ_RASTER_EN
  logic blk_start;

  // Order is latched per block, at the same points where idx restarts from 0
  assign blk_start = I_en & (((state == IDLE) & bank_full[rd_bank]) |
                             (blk_done & bank_full[~rd_bank]));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) raster_mode <= 1'b0;
    else if (blk_start) raster_mode <= I_raster;
  end
`else
  assign raster_mode = 1'b0;
`endif

  zz_order_rom u_rom (
    .idx  (idx),
    .addr (zz_addr)
  );

  assign rd_addr = raster_mode ? idx : zz_addr;
  assign O_data  = mem[{rd_bank, rd_addr}];
  assign O_valid = (state == STREAM);
  assign O_index = idx;
  assign O_last  = (state == STREAM) && (idx == 6'd63);

endmodule
